// File: rtl/idct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer between the row and column IDCT passes.
// Rows are written four samples per beat; columns are read back four per beat with round/saturate.
module idct_transpose_buf #(
  parameter int unsigned DW    = 25,
  parameter int unsigned OUT_W = 25,
  parameter int unsigned SHIFT = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic signed [DW-1:0]    d_in_1_i,
  input  logic signed [DW-1:0]    d_in_2_i,
  input  logic signed [DW-1:0]    d_in_3_i,
  input  logic signed [DW-1:0]    d_in_4_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [OUT_W-1:0] d_out_1_o,
  output logic signed [OUT_W-1:0] d_out_2_o,
  output logic signed [OUT_W-1:0] d_out_3_o,
  output logic signed [OUT_W-1:0] d_out_4_o,
  output logic                    blk_done_o
);

  typedef logic signed [DW-1:0] sample_t;
  typedef logic signed [OUT_W-1:0] osample_t;

  // One guard bit so the rounding add cannot overflow.
  localparam int unsigned XW = DW + 1;
  localparam logic signed [XW-1:0] Rnd    = XW'((2 ** SHIFT) >> 1);
  localparam logic signed [XW-1:0] SatMax = XW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [XW-1:0] SatMin = ~SatMax;

  sample_t  mem_q [2][8][8];
  sample_t  din [4];
  osample_t dout_q [4];
  osample_t dout_d [4];

  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [3:0] wr_beat_q, wr_beat_d;
  logic [3:0] rd_beat_q, rd_beat_d;
  logic [1:0] full_q, full_d;
  logic       out_valid_q, out_valid_d;
  logic       out_last_q, out_last_d;
  logic       in_fire;
  logic       out_load;

  function automatic osample_t scale_sat(input sample_t x);
    logic signed [XW-1:0] ext;
    logic signed [XW-1:0] y;
    ext = XW'(x);
    y   = (ext + Rnd) >>> SHIFT;
    if (y > SatMax) begin
      y = SatMax;
    end else if (y < SatMin) begin
      y = SatMin;
    end
    return y[OUT_W-1:0];
  endfunction

  assign din[0] = d_in_1_i;
  assign din[1] = d_in_2_i;
  assign din[2] = d_in_3_i;
  assign din[3] = d_in_4_i;

  assign in_ready_o  = ~full_q[wr_bank_q];
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_load    = (~out_valid_q | out_ready_i) & full_q[rd_bank_q];
  assign out_valid_o = out_valid_q;
  assign blk_done_o  = out_valid_q & out_ready_i & out_last_q;
  assign d_out_1_o   = dout_q[0];
  assign d_out_2_o   = dout_q[1];
  assign d_out_3_o   = dout_q[2];
  assign d_out_4_o   = dout_q[3];

  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_beat_d   = wr_beat_q;
    rd_bank_d   = rd_bank_q;
    rd_beat_d   = rd_beat_q;
    full_d      = full_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    for (int i = 0; i < 4; i++) begin
      dout_d[i] = dout_q[i];
    end

    if (in_fire) begin
      wr_beat_d = wr_beat_q + 4'd1;
      if (wr_beat_q == 4'd15) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    // Read and write never target the same bank in one cycle: a bank is written only while
    // empty and read only while full.
    if (out_load) begin
      rd_beat_d   = rd_beat_q + 4'd1;
      out_valid_d = 1'b1;
      out_last_d  = (rd_beat_q == 4'd15);
      for (int i = 0; i < 4; i++) begin
        dout_d[i] = scale_sat(mem_q[rd_bank_q][{rd_beat_q[0], 2'(i)}][rd_beat_q[3:1]]);
      end
      if (rd_beat_q == 4'd15) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_beat_q   <= '0;
      rd_beat_q   <= '0;
      full_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        dout_q[i] <= '0;
      end
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_beat_q   <= wr_beat_d;
      rd_beat_q   <= rd_beat_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      for (int i = 0; i < 4; i++) begin
        dout_q[i] <= dout_d[i];
      end
    end
  end

  // Sample storage needs no reset; the full flags gate every read.
  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[wr_bank_q][wr_beat_q[3:1]][{wr_beat_q[0], 2'(i)}] <= din[i];
      end
    end
  end

endmodule
